// File: rtl/alu_result_buffer.sv
// ALU output stage: computes N/Z/C/V flags on capture, buffers results in a 2-entry FIFO
// with valid/ready hand-off to write-back, and keeps a sticky overflow flag.
module alu_result_buffer #(
   parameter int unsigned Nbits = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [Nbits-1:0] RESULT,
   input  logic             CARRY_IN,
   input  logic             OVF_IN,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [Nbits-1:0] RES_Q,
   output logic [3:0]       FLAGS_Q,
   output logic [1:0]       COUNT,
   output logic             STICKY_V,
   input  logic             CLR_STICKY
);

   localparam int unsigned EntryW = Nbits + 4;

   logic [EntryW-1:0] r_mem [2];
   logic              r_wptr;
   logic              r_rptr;
   logic [1:0]        r_count;
   logic              r_sticky;

   logic              w_push;
   logic              w_pop;
   logic [EntryW-1:0] w_entry;
   logic [EntryW-1:0] w_head;

   // Ready looks only at the registered count, so a full buffer stalls one cycle after a pop.
   assign IN_READY  = (r_count != 2'd2);
   assign OUT_VALID = (r_count != 2'd0);
   assign w_push    = IN_VALID & IN_READY;
   assign w_pop     = OUT_VALID & OUT_READY;

   assign w_entry = {RESULT, RESULT[Nbits-1], (RESULT == '0), CARRY_IN, OVF_IN};
   assign w_head  = r_mem[r_rptr];

   assign RES_Q    = OUT_VALID ? w_head[EntryW-1:4] : '0;
   assign FLAGS_Q  = OUT_VALID ? w_head[3:0] : 4'b0000;
   assign COUNT    = r_count;
   assign STICKY_V = r_sticky;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= 2'd0;
         r_sticky <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= w_entry;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
         // A set from a popped overflow entry wins over a same-cycle clear.
         if (w_pop && w_head[0]) begin
            r_sticky <= 1'b1;
         end else if (CLR_STICKY) begin
            r_sticky <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: queue-based reference model checked every cycle,
// plus literal expectations taken from hand-worked scenarios.
module tb_alu_result_buffer;

   localparam int unsigned Nbits = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [Nbits-1:0] result;
   logic             carry_in;
   logic             ovf_in;
   logic             out_valid;
   logic             out_ready;
   logic [Nbits-1:0] res_q;
   logic [3:0]       flags_q;
   logic [1:0]       count;
   logic             sticky_v;
   logic             clr_sticky;

   int n_vec = 0;
   int n_bad = 0;
   bit check_en = 1'b0;

   typedef struct {
      logic [Nbits-1:0] res;
      logic [3:0]       flg;
   } ent_t;

   ent_t m_q[$];
   bit   m_sticky;

   alu_result_buffer #(.Nbits(Nbits)) dut (
      .CLK        (clk),
      .RST        (rst),
      .IN_VALID   (in_valid),
      .IN_READY   (in_ready),
      .RESULT     (result),
      .CARRY_IN   (carry_in),
      .OVF_IN     (ovf_in),
      .OUT_VALID  (out_valid),
      .OUT_READY  (out_ready),
      .RES_Q      (res_q),
      .FLAGS_Q    (flags_q),
      .COUNT      (count),
      .STICKY_V   (sticky_v),
      .CLR_STICKY (clr_sticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference behaviour: a plain queue of {result, flags} records.
   task automatic model_edge();
      ent_t e;
      bit   can_push;
      bit   can_pop;
      can_push = in_valid && (m_q.size() < 2);
      can_pop  = out_ready && (m_q.size() > 0);
      if (rst) begin
         m_q.delete();
         m_sticky = 1'b0;
      end else begin
         if (can_pop && m_q[0].flg[0]) m_sticky = 1'b1;
         else if (clr_sticky) m_sticky = 1'b0;
         if (can_pop) void'(m_q.pop_front());
         if (can_push) begin
            e.res = result;
            e.flg = {result[Nbits-1], (result == 0) ? 1'b1 : 1'b0, carry_in, ovf_in};
            m_q.push_back(e);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic drive(input bit iv, input logic [3:0] r, input bit c, input bit v,
                        input bit ordy, input bit clr, input bit rs);
      in_valid   = iv;
      result     = r;
      carry_in   = c;
      ovf_in     = v;
      out_ready  = ordy;
      clr_sticky = clr;
      rst        = rs;
      step();
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         chk("model_count", 32'(count), 32'(m_q.size()));
         chk("model_out_valid", 32'(out_valid), 32'(m_q.size() != 0));
         chk("model_in_ready", 32'(in_ready), 32'(m_q.size() != 2));
         chk("model_res_q", 32'(res_q), (m_q.size() != 0) ? 32'(m_q[0].res) : 32'd0);
         chk("model_flags_q", 32'(flags_q), (m_q.size() != 0) ? 32'(m_q[0].flg) : 32'd0);
         chk("model_sticky", 32'(sticky_v), 32'(m_sticky));
      end
   end

   initial begin
      drive(0, 4'h0, 0, 0, 0, 0, 1);
      drive(0, 4'h0, 0, 0, 0, 0, 1);
      check_en = 1'b1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_res_q", 32'(res_q), 32'd0);
      chk("rst_count", 32'(count), 32'd0);

      // Zero result with carry: flags {N,Z,C,V} = 0110.
      drive(1, 4'b0000, 1, 0, 0, 0, 0);
      chk("zero_out_valid", 32'(out_valid), 32'd1);
      chk("zero_flags", 32'(flags_q), 32'b0110);
      chk("zero_count", 32'(count), 32'd1);
      drive(0, 4'h0, 0, 0, 1, 0, 0);

      // Fill, ignored third push, drain.
      drive(1, 4'b1001, 0, 1, 0, 0, 0);
      drive(1, 4'b0011, 0, 0, 0, 0, 0);
      chk("full_count", 32'(count), 32'd2);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      drive(1, 4'b1111, 0, 0, 0, 0, 0);
      chk("ignored_count", 32'(count), 32'd2);
      chk("head1_res", 32'(res_q), 32'b1001);
      chk("head1_flags", 32'(flags_q), 32'b1001);
      drive(0, 4'h0, 0, 0, 1, 0, 0);
      chk("head2_res", 32'(res_q), 32'b0011);
      chk("head2_flags", 32'(flags_q), 32'b0000);
      chk("sticky_after_v_pop", 32'(sticky_v), 32'd1);
      drive(0, 4'h0, 0, 0, 1, 0, 0);
      chk("drained_valid", 32'(out_valid), 32'd0);
      chk("drained_res", 32'(res_q), 32'd0);
      drive(0, 4'h0, 0, 0, 0, 1, 0);
      chk("clr_sticky", 32'(sticky_v), 32'd0);

      // Streaming at occupancy 1.
      drive(1, 4'h0, 0, 0, 0, 0, 0);
      for (int v = 1; v <= 8; v++) begin
         drive(1, 4'(v), 0, 0, 1, 0, 0);
         chk("stream_res", 32'(res_q), 32'(v));
         chk("stream_count", 32'(count), 32'd1);
      end
      drive(0, 4'h0, 0, 0, 1, 0, 0);

      // Set beats clear on the same edge.
      drive(1, 4'b0111, 0, 1, 0, 0, 0);
      drive(0, 4'h0, 0, 0, 1, 1, 0);
      chk("set_wins", 32'(sticky_v), 32'd1);
      drive(0, 4'h0, 0, 0, 0, 1, 0);
      chk("clr_alone", 32'(sticky_v), 32'd0);

      // Reset overrides push and pop at full.
      drive(1, 4'b0110, 0, 1, 0, 0, 0);
      drive(0, 4'h0, 0, 0, 1, 0, 0);
      drive(1, 4'b1010, 0, 0, 0, 0, 0);
      drive(1, 4'b1100, 0, 0, 0, 0, 0);
      drive(1, 4'b0001, 0, 0, 1, 0, 1);
      chk("rst2_count", 32'(count), 32'd0);
      chk("rst2_out_valid", 32'(out_valid), 32'd0);
      chk("rst2_in_ready", 32'(in_ready), 32'd1);
      chk("rst2_sticky", 32'(sticky_v), 32'd0);
      chk("rst2_res", 32'(res_q), 32'd0);

      // Bubble at full, ordering across pointer wrap.
      drive(1, 4'b1110, 0, 0, 0, 0, 0);
      drive(0, 4'h0, 0, 0, 1, 0, 0);
      drive(1, 4'b0010, 0, 0, 0, 0, 0);
      drive(1, 4'b1000, 1, 0, 0, 0, 0);
      drive(1, 4'b0101, 0, 0, 1, 0, 0);
      chk("bubble_count", 32'(count), 32'd1);
      chk("bubble_head", 32'(res_q), 32'b1000);
      drive(1, 4'b0101, 0, 0, 0, 0, 0);
      chk("after_bubble_count", 32'(count), 32'd2);
      drive(0, 4'h0, 0, 0, 1, 0, 0);
      chk("wrap_head", 32'(res_q), 32'b0101);
      chk("wrap_flags", 32'(flags_q), 32'b0000);
      drive(0, 4'h0, 0, 0, 1, 0, 0);
      chk("wrap_empty", 32'(out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
